// File: rtl/mux_scan_sampler_pkg.sv
// Shared definitions for the mux scan sampler: channel count, select width
// and the sequencer state encoding.
package mux_scan_sampler_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DWELL = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage : mux_scan_sampler_pkg

// File: rtl/mux_scan_sampler_scan_next_ch.sv
// Priority finder: returns the lowest set channel of mask_i strictly above
// sel_i (or the lowest set channel overall when first_i is high), plus a
// last flag that is high when no such channel exists.
module scan_next_ch
  import mux_scan_sampler_pkg::*;
(
  input  logic [NUM_CH-1:0] mask_i,
  input  logic [SEL_W-1:0]  sel_i,
  input  logic              first_i,
  output logic [SEL_W-1:0]  next_ch_o,
  output logic              last_o
);

  logic hit_s;

  // Scan from the top channel down so the lowest qualifying channel wins.
  always_comb begin
    next_ch_o = {SEL_W{1'b0}};
    last_o    = 1'b1;
    hit_s     = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      hit_s     = mask_i[i] & (first_i | (i > int'(sel_i)));
      next_ch_o = hit_s ? SEL_W'(i) : next_ch_o;
      last_o    = last_o & ~hit_s;
    end
  end

endmodule : scan_next_ch

// File: rtl/mux_scan_sampler.sv
// Scan sequencer around a 4:1 enabled mux: walks the masked channels in
// ascending order, holds each for DWELL cycles, samples the mux output on
// the last dwell cycle and publishes the 4-bit snapshot with a done pulse.
module mux_scan_sampler
  import mux_scan_sampler_pkg::*;
#(
  parameter int DWELL = 2,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [NUM_CH-1:0] mask,
  output logic [SEL_W-1:0]  sel_o,
  output logic              en_o,
  input  logic              y_i,
  output logic              busy,
  output logic              done,
  output logic [NUM_CH-1:0] data_o
);

  localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL - 1);

  state_e              state_q;
  logic [SEL_W-1:0]    sel_q;
  logic                en_q;
  logic                busy_q;
  logic                done_q;
  logic [NUM_CH-1:0]   data_q;
  logic [NUM_CH-1:0]   mask_q;
  logic [NUM_CH-1:0]   shadow_q;
  logic [CNT_W-1:0]    cnt_q;

  logic [NUM_CH-1:0]   shadow_d;
  logic [NUM_CH-1:0]   scan_mask_s;
  logic                first_s;
  logic [SEL_W-1:0]    nxt_ch_s;
  logic                last_s;

  // In IDLE the finder looks at the live mask to pick the first channel;
  // during a scan it walks the latched copy so input changes are ignored.
  always_comb begin
    first_s     = (state_q == ST_IDLE);
    scan_mask_s = first_s ? mask : mask_q;
  end

  scan_next_ch u_next_ch (
    .mask_i    (scan_mask_s),
    .sel_i     (sel_q),
    .first_i   (first_s),
    .next_ch_o (nxt_ch_s),
    .last_o    (last_s)
  );

  // Shadow value including the bit sampled from the mux this cycle.
  always_comb begin
    shadow_d        = shadow_q;
    shadow_d[sel_q] = y_i;
  end

  // Sequencer FSM with all mux-facing and downstream outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      sel_q    <= {SEL_W{1'b0}};
      en_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      data_q   <= {NUM_CH{1'b0}};
      mask_q   <= {NUM_CH{1'b0}};
      shadow_q <= {NUM_CH{1'b0}};
      cnt_q    <= {CNT_W{1'b0}};
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          en_q   <= 1'b0;
          sel_q  <= {SEL_W{1'b0}};
          busy_q <= 1'b0;
          if (start) begin
            mask_q   <= mask;
            shadow_q <= {NUM_CH{1'b0}};
            if (mask != {NUM_CH{1'b0}}) begin
              state_q <= ST_DWELL;
              sel_q   <= nxt_ch_s;
              cnt_q   <= DWELL_LOAD;
              en_q    <= 1'b1;
              busy_q  <= 1'b1;
            end else begin
              // Empty mask: publish an all-zero snapshot straight away.
              state_q <= ST_DONE;
              done_q  <= 1'b1;
              data_q  <= {NUM_CH{1'b0}};
            end
          end else begin
            state_q <= ST_IDLE;
          end
        end

        ST_DWELL: begin
          if (abort) begin
            // Cancel wins over a same-cycle sample; snapshot is left intact.
            state_q <= ST_IDLE;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            sel_q   <= {SEL_W{1'b0}};
          end else if (cnt_q == {CNT_W{1'b0}}) begin
            shadow_q <= shadow_d;
            if (!last_s) begin
              // Move straight to the next channel with no idle gap.
              sel_q <= nxt_ch_s;
              cnt_q <= DWELL_LOAD;
            end else begin
              state_q <= ST_DONE;
              en_q    <= 1'b0;
              busy_q  <= 1'b0;
              sel_q   <= {SEL_W{1'b0}};
              done_q  <= 1'b1;
              data_q  <= shadow_d;
            end
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end

        ST_DONE: begin
          state_q <= ST_IDLE;
          en_q    <= 1'b0;
          busy_q  <= 1'b0;
          sel_q   <= {SEL_W{1'b0}};
        end

        default: begin
          state_q <= ST_IDLE;
          en_q    <= 1'b0;
          busy_q  <= 1'b0;
          sel_q   <= {SEL_W{1'b0}};
        end
      endcase
    end
  end

  assign sel_o  = sel_q;
  assign en_o   = en_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign data_o = data_q;

endmodule : mux_scan_sampler

// File: tb/tb_mux_scan_sampler.sv
// Self-checking bench for mux_scan_sampler. The expected behaviour of a scan
// is derived from the list of set mask bits: each listed channel occupies
// DWELL consecutive enabled cycles, then one done cycle carries inputs & mask.
module tb_mux_scan_sampler;

  localparam int DWELL = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic [3:0] mask;
  logic [1:0] sel_o;
  logic       en_o;
  logic       y_i;
  logic       busy;
  logic       done;
  logic [3:0] data_o;

  logic [3:0] iv;
  logic       noise;
  logic [3:0] snap;
  int         n_checks = 0;
  int         n_fail   = 0;

  always #5 clk = ~clk;

  // Behavioural enabled 4:1 mux; when disabled it returns a noise bit so a
  // sampler that wrongly captures outside the scan is visible.
  assign y_i = en_o ? iv[sel_o] : noise;

  mux_scan_sampler #(.DWELL(DWELL), .CNT_W(8)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .abort  (abort),
    .mask   (mask),
    .sel_o  (sel_o),
    .en_o   (en_o),
    .y_i    (y_i),
    .busy   (busy),
    .done   (done),
    .data_o (data_o)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full scan. abort_k > 0 cancels during that enabled cycle,
  // abort_k < 0 raises abort together with start, hold keeps start high
  // through the scan and its done cycle.
  task automatic do_scan(input logic [3:0] m, input logic [3:0] ivv,
                         input int abort_k, input bit hold);
    int         chans[$];
    int         total;
    logic [1:0] exp_sel;
    logic [3:0] exp_data;
    iv = ivv;
    for (int i = 0; i < 4; i++) if (m[i]) chans.push_back(i);
    total    = chans.size() * DWELL;
    exp_data = ivv & m;
    mask  = m;
    start = 1'b1;
    abort = (abort_k < 0);
    step();
    abort = 1'b0;
    if (!hold) start = 1'b0;
    for (int k = 1; k <= total; k++) begin
      exp_sel = 2'(chans[(k - 1) / DWELL]);
      n_checks++;
      if ({en_o, sel_o, busy, done, data_o} !== {1'b1, exp_sel, 1'b1, 1'b0, snap}) begin
        n_fail++;
        $display("FAIL scan_dwell mask=%b k=%0d en/sel/busy/done/data got %b required %b",
                 m, k, {en_o, sel_o, busy, done, data_o}, {1'b1, exp_sel, 1'b1, 1'b0, snap});
      end
      if (k == abort_k) abort = 1'b1;
      mask  = 4'($urandom);
      noise = 1'($urandom);
      step();
      abort = 1'b0;
      if (k == abort_k) begin
        for (int j = 0; j < 4; j++) begin
          n_checks++;
          if ({en_o, busy, done, data_o} !== {1'b0, 1'b0, 1'b0, snap}) begin
            n_fail++;
            $display("FAIL abort_idle j=%0d en/busy/done/data got %b required %b",
                     j, {en_o, busy, done, data_o}, {1'b0, 1'b0, 1'b0, snap});
          end
          step();
        end
        return;
      end
    end
    n_checks++;
    if ({en_o, sel_o, busy, done, data_o} !== {1'b0, 2'b00, 1'b0, 1'b1, exp_data}) begin
      n_fail++;
      $display("FAIL scan_done mask=%b en/sel/busy/done/data got %b required %b",
               m, {en_o, sel_o, busy, done, data_o}, {1'b0, 2'b00, 1'b0, 1'b1, exp_data});
    end
    snap = exp_data;
    step();
    start = 1'b0;
    n_checks++;
    if ({en_o, busy, done, data_o} !== {1'b0, 1'b0, 1'b0, snap}) begin
      n_fail++;
      $display("FAIL scan_after mask=%b en/busy/done/data got %b required %b",
               m, {en_o, busy, done, data_o}, {1'b0, 1'b0, 1'b0, snap});
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    mask  = 4'b0000;
    iv    = 4'b0000;
    noise = 1'b0;
    snap  = 4'b0000;
    #2;
    n_checks++;
    if ({sel_o, en_o, busy, done, data_o} !== 9'b0) begin
      n_fail++;
      $display("FAIL reset_state got %b required %b", {sel_o, en_o, busy, done, data_o}, 9'b0);
    end
    repeat (3) step();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      noise = 1'($urandom);
      mask  = 4'($urandom);
      step();
      n_checks++;
      if ({sel_o, en_o, busy, done, data_o} !== 9'b0) begin
        n_fail++;
        $display("FAIL idle_quiet i=%0d got %b required %b", i, {sel_o, en_o, busy, done, data_o}, 9'b0);
      end
    end
  endtask

  task automatic test_directed();
    do_scan(4'b1111, 4'b1010, 0, 1'b0);
    do_scan(4'b0101, 4'b1111, 0, 1'b0);
  endtask

  task automatic test_zero_mask();
    do_scan(4'b0000, 4'b1111, 0, 1'b0);
    do_scan(4'b1000, 4'b1000, 0, 1'b0);
    do_scan(4'b0000, 4'b0110, 0, 1'b0);
  endtask

  task automatic test_abort();
    do_scan(4'b1111, 4'b0110, 0, 1'b0);
    do_scan(4'b1111, 4'b1001, 5, 1'b0);
    do_scan(4'b0011, 4'b0001, -1, 1'b0);
    do_scan(4'b1111, 4'b1001, 0, 1'b0);
  endtask

  task automatic test_async_reset();
    iv    = 4'b1111;
    mask  = 4'b1111;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    #3 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({sel_o, en_o, busy, done, data_o} !== 9'b0) begin
      n_fail++;
      $display("FAIL async_reset got %b required %b", {sel_o, en_o, busy, done, data_o}, 9'b0);
    end
    snap = 4'b0000;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if ({sel_o, en_o, busy, done, data_o} !== 9'b0) begin
        n_fail++;
        $display("FAIL post_reset_idle i=%0d got %b required %b", i, {sel_o, en_o, busy, done, data_o}, 9'b0);
      end
    end
    do_scan(4'b1011, 4'($urandom), 0, 1'b0);
  endtask

  task automatic test_start_ignored();
    do_scan(4'b0110, 4'($urandom), 0, 1'b1);
    do_scan(4'b1001, 4'($urandom), 0, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++) begin
      do_scan(4'($urandom_range(0, 15)), 4'($urandom), 0, 1'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_zero_mask();
    test_abort();
    test_async_reset();
    test_start_ignored();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_mux_scan_sampler

// File: doc/mux_scan_sampler.md
Name: mux_scan_sampler

Overview:
- Sequencer that sits upstream and downstream of the 4:1 enabled multiplexer.
- Drives the mux select/enable to scan a masked set of the four channels, holding each for a settle interval.
- Samples the returned mux output at the end of each interval and presents the assembled 4-bit snapshot with a one-cycle done pulse.
- Converts the combinational mux into a periodic 4-channel bit sampler for downstream logic.

Parameters:
DWELL, 2, cycles each selected channel is held with enable high before sampling; legal range 1..255.
CNT_W, 8, width of the dwell counter; must satisfy 2**CNT_W > DWELL.

Ports:
clk  input  1  single system clock, rising-edge.
rst_n  input  1  reset, asynchronous assert, active-low.
start  input  1  request a scan; sampled only in IDLE.
abort  input  1  synchronous cancel of an in-progress scan.
mask  input  4  channels to scan; bit i = channel i; latched on accepted start.
sel_o  output  2  select to mux S.
en_o  output  1  enable to mux E.
y_i  input  1  mux output Y.
busy  output  1  high from the cycle after an accepted start until done.
done  output  1  one-cycle pulse; data_o is valid and updated this cycle.
data_o  output  4  last completed snapshot; bit i = sampled value of channel i, 0 for masked-off channels.

Behaviour:
- One clock; reset is asynchronous and active-low: rst_n low immediately forces state=IDLE, sel_o=0, en_o=0, busy=0, done=0, data_o=0, the counter and the shadow register to 0.
- FSM states:
  - IDLE: en_o=0, sel_o=0. On start=1, latch mask into mask_q. If mask≠0, go to DWELL_ST with sel_o = lowest set bit, counter = DWELL-1, and clear the shadow register. If mask=0, go to DONE with shadow=0.
  - DWELL_ST: en_o=1, busy=1, sel_o stable. The counter decrements each cycle. In the cycle the counter=0, y_i is captured into shadow[sel_o] at that clock edge. If a higher set bit remains in mask_q, sel_o advances to the next set bit and the counter reloads DWELL-1, with no idle cycle between channels. Otherwise the FSM goes to DONE.
  - DONE: done=1, en_o=0, busy=0, data_o←shadow on entry. Return to IDLE the next cycle. A start arriving in DONE is ignored.
- Latency:
  - With n set mask bits, en_o is high for exactly n×DWELL consecutive cycles beginning the cycle after the start edge.
  - done is asserted n×DWELL+1 cycles after the accepted start edge.
  - mask=0 gives done one cycle after start.
- Scan order is ascending channel index; masked-off channels are skipped and never selected.
- start while not in IDLE is ignored. mask changes after acceptance have no effect on the scan in progress.
- abort=1 in DWELL_ST returns the FSM to IDLE next cycle: en_o=0, no done pulse, data_o unchanged. abort has priority over a same-cycle sample/advance. abort in IDLE or DONE has no effect; done still pulses.
- abort and start both high in IDLE: start is accepted.
- rst_n asserted mid-scan: all outputs clear as above. The partial snapshot is discarded.
- data_o changes only in the DONE cycle or on reset.

Decomposition:
- Shared package: FSM state encoding (IDLE, DWELL_ST, DONE), NUM_CH=4, SEL_W=2.
- One sub-module, scan_next_ch: combinational priority finder. Given mask_q and the current sel, it returns the next higher set channel plus a "last" flag. At start it is used with sel=−1 semantics to find the first channel.

Test Plan:
- Reset then idle, y_i toggling: sel_o=0, en_o=0, busy=0, done never asserts, data_o=0.
- DWELL=2, mask=4'b1111, y_i driven as I[sel_o] with I=4'b1010: sel_o sequence 0,0,1,1,2,2,3,3 with en_o high 8 cycles; done 9 cycles after start; data_o=4'b1010.
- mask=4'b0101, I=4'b1111: only channels 0 and 2 selected, en_o high 4 cycles; data_o=4'b0101; done at cycle 5.
- mask=4'b0000 start: done the next cycle, data_o=0, en_o never high.
- Scan with mask=4'b1111, abort asserted during channel 2: en_o low the next cycle, no done pulse, data_o retains the previous snapshot. A new start then completes normally.
- rst_n pulsed low asynchronously mid-scan, then released: outputs clear immediately. start held high throughout the scan and during DONE is ignored; a start after IDLE returns begins a fresh scan.
